// File: rtl/tdm_demux_if.sv
// Sample bus and lane outputs of the TDM demultiplexer, bundled.
// Latency: n/a (wires only).
// Backpressure: none; the source drives one sample per enabled cycle.
//
// Ports grouped here:
//   en, sync, d, err_clr             : sample side (source -> demux)
//   y, valid, frame_done, s,
//   locked, sync_err                 : lane/status side (demux -> sink)
interface tdm_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SW = $clog2(CHANNELS);

  logic                      en;
  logic                      sync;
  logic [WIDTH-1:0]          d;
  logic                      err_clr;
  logic [CHANNELS*WIDTH-1:0] y;
  logic [CHANNELS-1:0]       valid;
  logic                      frame_done;
  logic [SW-1:0]             s;
  logic                      locked;
  logic                      sync_err;

  // Sample source / bench side.
  modport master (
    output en, sync, d, err_clr,
    input  y, valid, frame_done, s, locked, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  en, sync, d, err_clr,
    output y, valid, frame_done, s, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: fans a slotted serial sample stream out into CHANNELS lane registers.
// Latency: lane/valid/frame_done visible 1 cycle after the enabled input cycle; 1 sample/cycle.
// Backpressure: none; every en=1 sample is consumed (or discarded while hunting for sync).
//
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : tdm_demux_if.slave (en/sync/d/err_clr in; y/valid/frame_done/s/locked/sync_err out)
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_if.slave   bus
);
  localparam int SW = $clog2(CHANNELS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             s_q, s_d;
  logic [CHANNELS*WIDTH-1:0] y_q;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic                      frame_q, frame_d;
  logic                      err_q;
  logic                      cap;
  logic [SW-1:0]             lane_sel;
  logic                      err_set;

  // Next-state and capture decode.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cap      = 1'b0;
    lane_sel = '0;
    frame_d  = 1'b0;
    err_set  = 1'b0;
    if (bus.en) begin
      case (state_q)
        HUNT: begin
          // Everything before the first sync is discarded.
          if (bus.sync) begin
            cap      = 1'b1;
            lane_sel = '0;
            s_d      = SW'(1);
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.sync && (s_q != '0)) begin
            // Misaligned sync: restart the frame at slot 0 and abandon the
            // partial frame, so no frame_done for it.
            cap      = 1'b1;
            lane_sel = '0;
            s_d      = SW'(1);
            err_set  = 1'b1;
          end else begin
            cap      = 1'b1;
            lane_sel = s_q;
            s_d      = s_q + SW'(1); // power-of-2 CHANNELS: natural wrap
            frame_d  = (s_q == SW'(CHANNELS - 1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    valid_d = '0;
    if (cap) valid_d[lane_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      s_q     <= '0;
      y_q     <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      for (int k = 0; k < CHANNELS; k++) begin
        if (cap && (lane_sel == SW'(k))) y_q[k*WIDTH +: WIDTH] <= bus.d;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      if (err_set)          err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.y          = y_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_q;
  assign bus.s          = s_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.sync_err   = err_q;
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Sequential 1-to-CHANNELS time-division demultiplexer. Accepts one WIDTH-bit sample per enabled cycle from a shared serial-slot bus and writes it into the per-channel output register selected by an internal slot counter. A frame-sync input aligns the counter. The block is the receive-side counterpart of the lab's multiplexer datapath: it fans a selected stream back out into parallel lanes.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- CHANNELS, 4, number of output lanes; power of 2, ≥2
- SW, $clog2(CHANNELS), slot-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample qualifier; d and sync are sampled only when en=1
- sync  in  1  marks the current sample as slot 0 (valid only with en=1)
- d  in  WIDTH  input sample
- err_clr  in  1  clears sync_err
- y  out  CHANNELS*WIDTH  lane registers; lane k = y[k*WIDTH +: WIDTH]
- valid  out  CHANNELS  one-cycle pulse on bit k when lane k is updated
- frame_done  out  1  one-cycle pulse when slot CHANNELS-1 is captured
- s  out  SW  slot index the next enabled sample will be written to
- locked  out  1  high once frame alignment is acquired
- sync_err  out  1  sticky; sync seen at a slot other than 0 while locked

## Operation
- Reset values (async, immediate): y=0, valid=0, frame_done=0, s=0, locked=0, sync_err=0, state=HUNT.
- State machine: HUNT and LOCKED.
- HUNT
  - en=1 and sync=0: sample discarded. No valid pulse. s stays 0.
  - en=1 and sync=1: capture d into lane 0 and pulse valid[0]. Set s=1 and go to LOCKED (locked=1).
- LOCKED, en=1 and sync=0
  - Capture d into lane s and pulse valid[s].
  - s increments modulo CHANNELS (CHANNELS-1 wraps to 0).
  - If s was CHANNELS-1, pulse frame_done.
- LOCKED, en=1 and sync=1
  - s==0: normal capture into lane 0; no error.
  - s!=0: resync. Capture d into lane 0, pulse valid[0], set s=1 and set sync_err. The partial frame is abandoned: lanes not yet written keep their old values and frame_done does not fire.
- en=0, any state: no capture, no pulses, s and state hold, sync is ignored.
- Unwritten lanes always hold their last value. Only one lane changes per cycle.
- err_clr=1 clears sync_err next edge. If a new error occurs in the same cycle, set wins and sync_err stays 1.
- locked is left only by reset. A mid-frame reset discards the partial frame and returns to HUNT.
- With CHANNELS=2, SW=1 and s toggles 0/1.

## Timing
- All outputs are registered.
- y lane update, valid and frame_done appear 1 cycle after the capturing edge, i.e. visible in the cycle following the en=1 cycle.
- valid and frame_done are high for exactly one cycle per capture. Back-to-back en=1 cycles give a capture every cycle, so a full frame takes CHANNELS consecutive enabled cycles.
- frame_done coincides with valid[CHANNELS-1].
- s and locked update on the same edge as the capture.
- sync_err rises on the edge that captures the misaligned sync.
- Throughput: 1 sample/cycle. No backpressure.

## Test plan
(WIDTH=8, CHANNELS=4)
- Reset, then en=0 for 5 cycles, then en=1/sync=0 with d=0x11 for 3 cycles -> y=0, valid=0, s=0, locked=0 throughout.
- HUNT, then en=1 with sync=1 on d=0xA0, then d=0xA1, 0xA2, 0xA3 -> the following are pulsed in sequence:
  - valid = 0001, 0010, 0100, 1000;
  - y = 0xA3A2A1A0;
  - frame_done pulses with valid=1000;
  - s returns to 0 and locked=1.
- Locked at s=0; feed 0xB0 and 0xB1, deassert en for 3 cycles, then feed 0xB2 and 0xB3 -> no pulses while en=0, s holds at 2, frame completes with y=0xB3B2B1B0.
- Locked at s=2; assert sync with d=0xC0 -> lane 0=0xC0, valid=0001, s=1, sync_err=1, no frame_done. Then err_clr=1 with no new error -> sync_err=0 next cycle.
- Locked at s=3; assert sync (error) and err_clr in the same cycle -> sync_err remains 1.
- Mid-frame at s=2, assert rst for 1 cycle (asynchronous, between edges) -> outputs immediately at reset values. A following en=1/sync=0 sample is ignored (HUNT).
